// File: rtl/imem_responder.sv
// imem_responder: instruction memory that the CPU fetches from.
// A streaming load port fills the memory with the program. The block holds the
// CPU in reset until the load finishes. It then answers each sampled pc_i with
// the instruction word one cycle later.
// Optional build macro IMEM_MISALIGN_TRAP_EN: when defined, a misaligned fetch
// traps into a sticky FAULT state. The only way out of FAULT is rst_n.
module imem_responder #(
  parameter int unsigned DEPTH    = 256,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  output logic [31:0] ins_o,
  output logic        ins_valid_o,
  output logic        cpu_rst_n_o,
  input  logic        ld_valid_i,
  output logic        ld_ready_o,
  input  logic [31:0] ld_data_i,
  input  logic        ld_last_i,
  output logic        fault_o,
  output logic [31:0] fault_pc_o,
  output logic [31:0] fetch_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [AW-1:0] wptr_reg, wptr_next;
  logic        sel_nop_reg, sel_nop_next;   // output the NOP word instead of the memory word
  logic        ins_valid_reg, ins_valid_next;
  logic        cpu_rst_n_reg, cpu_rst_n_next;
  logic [31:0] fetch_cnt_reg, fetch_cnt_next;
  logic        fault_reg, fault_next;
  logic [31:0] fault_pc_reg, fault_pc_next;

  // Storage. It is not reset. The read port is registered on every cycle so
  // that it maps onto block RAM.
  logic [31:0] mem [DEPTH];
  logic [31:0] mem_q;

  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] rd_idx;
  logic          misalign;
  logic          wr_en;
  logic          full;

  assign offset   = pc_i - RESET_PC;
  assign in_range = (offset[31:AW+2] == '0);
  assign rd_idx   = offset[AW+1:2];
  assign wr_en    = (state_reg == LOAD) && ld_valid_i;
  assign full     = (wptr_reg == AW'(DEPTH - 1));

`ifdef IMEM_MISALIGN_TRAP_EN
  assign misalign = (pc_i[1:0] != 2'b00);
  logic  unused_bits;
  assign unused_bits = &{1'b0, offset[1:0]};
`else
  // The byte-offset bits of pc_i do not take part in a fetch in this build.
  assign misalign = 1'b0;
  logic  unused_bits;
  assign unused_bits = &{1'b0, offset[1:0], fault_reg, fault_pc_reg};
`endif

  // Program write port and registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr_reg] <= ld_data_i;
    end
    mem_q <= mem[rd_idx];
  end

  // Next-state and next-output logic. Every target gets a default first.
  always_comb begin
    state_next     = state_reg;
    wptr_next      = wptr_reg;
    sel_nop_next   = 1'b1;
    ins_valid_next = 1'b0;
    cpu_rst_n_next = 1'b0;
    fetch_cnt_next = fetch_cnt_reg;
    fault_next     = fault_reg;
    fault_pc_next  = fault_pc_reg;

    case (state_reg)
      LOAD: begin
        if (ld_valid_i) begin
          wptr_next = wptr_reg + AW'(1);
          // A last beat that is also the full beat gives a single transition.
          if (ld_last_i || full) begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (fetch_cnt_reg != 32'hFFFF_FFFF) begin
          fetch_cnt_next = fetch_cnt_reg + 32'd1;
        end
        // The alignment check has priority over the range check.
        if (misalign) begin
          state_next    = FAULT;
          fault_next    = 1'b1;
          fault_pc_next = pc_i;
        end else begin
          sel_nop_next   = !in_range;
          ins_valid_next = 1'b1;
          cpu_rst_n_next = 1'b1;
        end
      end
      FAULT: begin
        // Held here with NOP output and the CPU in reset until rst_n.
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  // State and output registers, asynchronously reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= LOAD;
      wptr_reg      <= '0;
      sel_nop_reg   <= 1'b1;
      ins_valid_reg <= 1'b0;
      cpu_rst_n_reg <= 1'b0;
      fetch_cnt_reg <= '0;
      fault_reg     <= 1'b0;
      fault_pc_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      wptr_reg      <= wptr_next;
      sel_nop_reg   <= sel_nop_next;
      ins_valid_reg <= ins_valid_next;
      cpu_rst_n_reg <= cpu_rst_n_next;
      fetch_cnt_reg <= fetch_cnt_next;
      fault_reg     <= fault_next;
      fault_pc_reg  <= fault_pc_next;
    end
  end

  assign ins_o       = sel_nop_reg ? NOP_WORD : mem_q;
  assign ins_valid_o = ins_valid_reg;
  assign cpu_rst_n_o = cpu_rst_n_reg;
  assign ld_ready_o  = (state_reg == LOAD);
  assign fetch_cnt_o = fetch_cnt_reg;

`ifdef IMEM_MISALIGN_TRAP_EN
  assign fault_o    = fault_reg;
  assign fault_pc_o = fault_pc_reg;
`else
  assign fault_o    = 1'b0;
  assign fault_pc_o = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed testbench for imem_responder (DEPTH=256, RESET_PC=0).
// The expected values were worked out by hand.
module tb_imem_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] ins;
  logic        ins_valid;
  logic        cpu_rst_n;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  imem_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_i        (pc),
    .ins_o       (ins),
    .ins_valid_o (ins_valid),
    .cpu_rst_n_o (cpu_rst_n),
    .ld_valid_i  (ld_valid),
    .ld_ready_o  (ld_ready),
    .ld_data_i   (ld_data),
    .ld_last_i   (ld_last),
    .fault_o     (fault),
    .fault_pc_o  (fault_pc),
    .fetch_cnt_o (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // Wait for one rising edge, then settle so that sampling happens away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_beat(input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    pc       = 32'h0;
    ld_valid = 1'b0;
    ld_data  = 32'h0;
    ld_last  = 1'b0;
    tick();

    // Reset state
    chk("rst_ld_ready",  {31'b0, ld_ready},  32'h1);
    chk("rst_cpu_rst_n", {31'b0, cpu_rst_n}, 32'h0);
    chk("rst_ins_valid", {31'b0, ins_valid}, 32'h0);
    chk("rst_ins",       ins,                32'h0000_0013);
    chk("rst_fault",     {31'b0, fault},     32'h0);
    chk("rst_fault_pc",  fault_pc,           32'h0);
    chk("rst_fetch_cnt", fetch_cnt,          32'h0);
    tick();
    rst_n = 1'b1;

    // A four-beat program with last on beat 4
    load_beat(32'hAAAA_0001, 1'b0);
    load_beat(32'hAAAA_0002, 1'b0);
    load_beat(32'hAAAA_0003, 1'b0);
    chk("ld4_ready_before", {31'b0, ld_ready}, 32'h1);
    load_beat(32'hAAAA_0004, 1'b1);
    chk("ld4_ready_after", {31'b0, ld_ready},  32'h0);
    chk("ld4_cpu_rst_n",   {31'b0, cpu_rst_n}, 32'h0);
    chk("ld4_cnt0",        fetch_cnt,          32'h0);
    pc = 32'h0;
    tick();
    chk("run1_cpu_rst_n", {31'b0, cpu_rst_n}, 32'h1);
    chk("run1_valid",     {31'b0, ins_valid}, 32'h1);
    chk("run1_ins_pc0",   ins,                32'hAAAA_0001);
    chk("run1_cnt",       fetch_cnt,          32'h1);
    pc = 32'h4;
    tick();
    chk("pc4_ins",   ins,                32'hAAAA_0002);
    chk("pc4_valid", {31'b0, ins_valid}, 32'h1);
    chk("pc4_cnt",   fetch_cnt,          32'h2);
    pc = 32'h400;
    tick();
    chk("pc400_nop",   ins,                32'h0000_0013);
    chk("pc400_valid", {31'b0, ins_valid}, 32'h1);
    pc = 32'hC;
    tick();
    chk("pcC_ins", ins, 32'hAAAA_0004);
    pc = 32'h6;
    tick();
    chk("pc6_cnt", fetch_cnt, 32'h5);
`ifdef IMEM_MISALIGN_TRAP_EN
    chk("pc6_fault",     {31'b0, fault},     32'h1);
    chk("pc6_fault_pc",  fault_pc,           32'h6);
    chk("pc6_cpu_rst_n", {31'b0, cpu_rst_n}, 32'h0);
    chk("pc6_ins_nop",   ins,                32'h0000_0013);
    chk("pc6_valid",     {31'b0, ins_valid}, 32'h0);
    pc = 32'h4;
    tick();
    chk("hold_fault",    {31'b0, fault},     32'h1);
    chk("hold_fault_pc", fault_pc,           32'h6);
    chk("hold_ins",      ins,                32'h0000_0013);
    chk("hold_cnt",      fetch_cnt,          32'h5);
    chk("hold_ld_ready", {31'b0, ld_ready},  32'h0);
`else
    chk("pc6_ins_word1", ins,                32'hAAAA_0002);
    chk("pc6_fault",     {31'b0, fault},     32'h0);
    chk("pc6_fault_pc",  fault_pc,           32'h0);
    chk("pc6_valid",     {31'b0, ins_valid}, 32'h1);
`endif

    // Reset in the middle of a load
    do_reset();
    load_beat(32'hBBBB_0001, 1'b0);
    load_beat(32'hBBBB_0002, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ld_ready",  {31'b0, ld_ready},  32'h1);
    chk("midrst_cpu_rst_n", {31'b0, cpu_rst_n}, 32'h0);
    chk("midrst_valid",     {31'b0, ins_valid}, 32'h0);
    chk("midrst_cnt",       fetch_cnt,          32'h0);
    tick();
    rst_n = 1'b1;
    load_beat(32'hCCCC_0000, 1'b1);
    pc = 32'h0;
    tick();
    chk("midrst_word0", ins, 32'hCCCC_0000);
    pc = 32'h4;
    tick();
    chk("midrst_word1_kept", ins, 32'hBBBB_0002);

    // Fill all 256 words without ld_last
    do_reset();
    for (int i = 0; i < 256; i++) begin
      if (i == 255) chk("full_ready_before_last", {31'b0, ld_ready}, 32'h1);
      load_beat(32'h1000_0000 + i, 1'b0);
    end
    chk("full_ready_after", {31'b0, ld_ready}, 32'h0);
    // Offer a 257th beat. The port must refuse it.
    ld_valid = 1'b1;
    ld_data  = 32'hDEAD_BEEF;
    pc       = 32'h0;
    tick();
    chk("full_extra_ready", {31'b0, ld_ready}, 32'h0);
    chk("full_word0",       ins,               32'h1000_0000);
    pc = 32'h3FC;
    tick();
    chk("full_word255", ins, 32'h1000_00FF);
    pc = 32'h3F8;
    tick();
    chk("full_word254", ins, 32'h1000_00FE);
    pc = 32'h0;
    tick();
    chk("full_word0_again", ins, 32'h1000_0000);
    ld_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
